// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, owner encoding, watchdog default
// and the round-robin pick used in IDLE.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DBG = 1'b1
   } owner_t;

   localparam int DEF_TIMEOUT_CYCLES = 16;

   // A lone eligible requester wins; on a tie the one that did not go last wins.
   function automatic owner_t rr_pick(input logic cpu_elig, input logic dbg_elig,
                                      input owner_t last_owner);
      if (cpu_elig && dbg_elig)
         return (last_owner == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
      else if (dbg_elig)
         return OWNER_DBG;
      else
         return OWNER_CPU;
   endfunction

endpackage

// File: rtl/dmem_arb_watchdog.sv
// Per-requester starvation watchdog: saturating count of pending-not-granted cycles with a
// sticky flag set on the edge the count reaches TIMEOUT_CYCLES; never stalls the requester.
module dmem_arb_watchdog
   import dmem_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   input  logic gnt,
   output logic starve
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;

   always_comb begin
      cnt_nxt = cnt;
      if (!req || gnt)
         cnt_nxt = '0;
      else if (cnt != CNT_MAX)
         cnt_nxt = cnt + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt    <= '0;
         starve <= 1'b0;
      end else begin
         cnt <= cnt_nxt;
         if (cnt_nxt == CNT_MAX)
            starve <= 1'b1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter/sequencer sharing one sync data memory between CPU and debug ports (DMEM_ARB_WATCHDOG_EN adds fault_starve).
// gnt + mem_en one cycle after req is sampled in IDLE, rvalid one cycle later; requesters hold req until gnt.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
`ifdef DMEM_ARB_WATCHDOG_EN
   , parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`endif
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   input  logic              dbg_lock,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_WATCHDOG_EN
   , output logic            fault_starve
`endif
);

   state_t            state;
   state_t            state_nxt;
   owner_t            last_owner;
   owner_t            win_owner;
   owner_t            cmd_owner;
   logic              cmd_we;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              cmd_load;
   logic              cpu_elig;
   logic              dbg_elig;

   assign cpu_elig = cpu_req && !dbg_lock;
   assign dbg_elig = dbg_req;

   always_comb begin
      state_nxt = state;
      cmd_load  = 1'b0;
      win_owner = rr_pick(cpu_elig, dbg_elig, last_owner);
      case (state)
         IDLE: begin
            if (cpu_elig || dbg_elig) begin
               cmd_load  = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE:   state_nxt = cmd_we ? IDLE : RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_owner <= OWNER_CPU;
         cmd_owner  <= OWNER_CPU;
         cmd_we     <= 1'b0;
         cmd_addr   <= '0;
         cmd_wdata  <= '0;
      end else begin
         state <= state_nxt;
         // Command is frozen here; requester-side changes after this edge are ignored.
         if (cmd_load) begin
            cmd_owner <= win_owner;
            cmd_we    <= (win_owner == OWNER_DBG) ? dbg_we    : cpu_we;
            cmd_addr  <= (win_owner == OWNER_DBG) ? dbg_addr  : cpu_addr;
            cmd_wdata <= (win_owner == OWNER_DBG) ? dbg_wdata : cpu_wdata;
         end
         if (state == ISSUE)
            last_owner <= cmd_owner;
      end
   end

   assign mem_en     = (state == ISSUE);
   assign mem_we     = (state == ISSUE) && cmd_we;
   assign mem_addr   = (state == ISSUE) ? cmd_addr : '0;
   assign mem_wdata  = ((state == ISSUE) && cmd_we) ? cmd_wdata : '0;

   assign cpu_gnt    = (state == ISSUE) && (cmd_owner == OWNER_CPU);
   assign dbg_gnt    = (state == ISSUE) && (cmd_owner == OWNER_DBG);
   assign cpu_rvalid = (state == RESP)  && (cmd_owner == OWNER_CPU);
   assign dbg_rvalid = (state == RESP)  && (cmd_owner == OWNER_DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

`ifdef DMEM_ARB_WATCHDOG_EN
   logic cpu_starve;
   logic dbg_starve;

   dmem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd_cpu (
      .clk    (clk),
      .reset  (reset),
      .req    (cpu_req),
      .gnt    (cpu_gnt),
      .starve (cpu_starve)
   );

   dmem_arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd_dbg (
      .clk    (clk),
      .reset  (reset),
      .req    (dbg_req),
      .gnt    (dbg_gnt),
      .starve (dbg_starve)
   );

   assign fault_starve = cpu_starve || dbg_starve;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-schedule reference model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized read/write mix.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        cpu_req = 1'b0, cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0] dbg_addr = '0, dbg_wdata = '0;
   logic        dbg_lock = 1'b0;
   logic        cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [31:0] cpu_rdata, dbg_rdata;
   logic        mem_en, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
`ifdef DMEM_ARB_WATCHDOG_EN
   logic        fault_starve;
   localparam int TO = 16;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .dbg_lock(dbg_lock),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_WATCHDOG_EN
      , .fault_starve(fault_starve)
`endif
   );

   // Synchronous single-port memory seen by the DUT.
   logic [31:0] env_mem [16] = '{default: 32'd0};
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) env_mem[mem_addr[5:2]] <= mem_wdata;
         else        mem_rdata <= env_mem[mem_addr[5:2]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s: dut=%0h expected=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one access at a time, owner chosen by round robin at each free edge.
   typedef struct packed {
      logic        v;
      logic        own;   // 1 = debug port
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
   } iss_t;

   iss_t        cur_iss = '0;
   logic        resp_v = 1'b0, resp_own = 1'b0;
   logic [31:0] resp_dat = '0;
   logic [31:0] ref_mem [16] = '{default: 32'd0};
   int          edge_n = 0, free_at = 0;
   logic        m_last = 1'b0;
`ifdef DMEM_ARB_WATCHDOG_EN
   int          w_cpu = 0, w_dbg = 0;
   logic        m_fault = 1'b0;
`endif

   always @(posedge clk) begin
      logic ce, de, win, nr_v;
      edge_n++;
      if (reset) begin
         cur_iss = '0; resp_v = 1'b0; free_at = 0; m_last = 1'b0;
`ifdef DMEM_ARB_WATCHDOG_EN
         w_cpu = 0; w_dbg = 0; m_fault = 1'b0;
`endif
      end else begin
`ifdef DMEM_ARB_WATCHDOG_EN
         w_cpu = (cpu_req && !(cur_iss.v && !cur_iss.own)) ? w_cpu + 1 : 0;
         w_dbg = (dbg_req && !(cur_iss.v &&  cur_iss.own)) ? w_dbg + 1 : 0;
         if (w_cpu >= TO || w_dbg >= TO) m_fault = 1'b1;
`endif
         nr_v = 1'b0;
         if (cur_iss.v) begin
            if (cur_iss.we) ref_mem[cur_iss.addr[5:2]] = cur_iss.wd;
            else begin
               nr_v = 1'b1; resp_own = cur_iss.own; resp_dat = ref_mem[cur_iss.addr[5:2]];
            end
         end
         resp_v = nr_v;
         cur_iss = '0;
         ce = cpu_req && !dbg_lock;
         de = dbg_req;
         if (edge_n >= free_at && (ce || de)) begin
            win = (ce && de) ? !m_last : de;
            cur_iss.v    = 1'b1;
            cur_iss.own  = win;
            cur_iss.we   = win ? dbg_we    : cpu_we;
            cur_iss.addr = win ? dbg_addr  : cpu_addr;
            cur_iss.wd   = win ? dbg_wdata : cpu_wdata;
            m_last  = win;
            free_at = edge_n + (cur_iss.we ? 2 : 3);
         end
      end
   end

   always @(negedge clk) begin
      logic        e_cg, e_dg, e_cv, e_dv, e_en, e_we;
      logic [31:0] e_cd, e_dd;
      if (edge_n > 0) begin
         e_cg = 0; e_dg = 0; e_cv = 0; e_dv = 0; e_en = 0; e_we = 0; e_cd = '0; e_dd = '0;
         if (!reset) begin
            if (cur_iss.v) begin
               e_en = 1'b1; e_we = cur_iss.we; e_cg = !cur_iss.own; e_dg = cur_iss.own;
            end
            if (resp_v) begin
               if (resp_own) begin e_dv = 1'b1; e_dd = resp_dat; end
               else          begin e_cv = 1'b1; e_cd = resp_dat; end
            end
         end
         chk("cpu_gnt", cpu_gnt, e_cg);
         chk("dbg_gnt", dbg_gnt, e_dg);
         chk("cpu_rvalid", cpu_rvalid, e_cv);
         chk("dbg_rvalid", dbg_rvalid, e_dv);
         chk("cpu_rdata", cpu_rdata, e_cd);
         chk("dbg_rdata", dbg_rdata, e_dd);
         chk("mem_en", mem_en, e_en);
         chk("mem_we", mem_we, e_we);
         if (e_en) chk("mem_addr", mem_addr, cur_iss.addr);
         if (e_we) chk("mem_wdata", mem_wdata, cur_iss.wd);
`ifdef DMEM_ARB_WATCHDOG_EN
         chk("fault_starve", fault_starve, reset ? 1'b0 : m_fault);
`endif
      end
   end

   task automatic do_reset();
      @(posedge clk); #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic rand_cmd(output logic we, output logic [31:0] addr, output logic [31:0] wd);
      we   = 1'($urandom_range(0, 1));
      addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      wd   = $urandom;
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

   initial begin
      logic order [4];
      logic exp_order [4];
      int   ng, seen, lat, grants, rd_seen;

      // Reset state
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_cpu_gnt", cpu_gnt, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      reset = 1'b0;

      // CPU store 15 to 0x0, then load it back
      @(negedge clk);
      cpu_req = 1; cpu_we = 1; cpu_addr = 32'h0; cpu_wdata = 32'd15;
      @(negedge clk);
      chk("t1_st_gnt", cpu_gnt, 1);
      chk("t1_st_mem_we", mem_we, 1);
      chk("t1_st_wdata", mem_wdata, 15);
      cpu_req = 0;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h0; cpu_wdata = 32'hdead_beef;
      @(negedge clk);
      chk("t1_ld_gnt", cpu_gnt, 1);
      chk("t1_ld_mem_we", mem_we, 0);
      cpu_req = 0;
      @(negedge clk);
      chk("t1_ld_rvalid", cpu_rvalid, 1);
      chk("t1_ld_rdata", cpu_rdata, 15);

      // Simultaneous loads held from reset: dbg, cpu, dbg, cpu
      @(posedge clk); #2 reset = 1'b1;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h8;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;
      ng = 0;
      for (int c = 0; c < 40 && ng < 4; c++) begin
         @(negedge clk);
         if (cpu_gnt && ng < 4) begin order[ng] = 0; ng++; end
         if (dbg_gnt && ng < 4) begin order[ng] = 1; ng++; end
      end
      chk("t2_grant_count", ng, 4);
      for (int i = 0; i < 4; i++)
         if (i < ng) chk($sformatf("t2_order_%0d", i), order[i], exp_order[i]);
      cpu_req = 0; dbg_req = 0;

      // Debug lock starves the CPU
      do_reset();
      dbg_lock = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 32'hc;
      seen = 0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (cpu_gnt) seen++;
`ifdef DMEM_ARB_WATCHDOG_EN
         if (c == 15) chk("t3_fault_before_16", fault_starve, 0);
         if (c == 16) chk("t3_fault_at_16", fault_starve, 1);
`endif
      end
      chk("t3_no_gnt_while_locked", seen, 0);
      dbg_lock = 0;
      lat = 0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         if (cpu_gnt) begin lat = c; break; end
      end
      chk("t3_gnt_after_unlock", (lat >= 1 && lat <= 2), 1);
      cpu_req = 0;
      repeat (4) @(negedge clk);
`ifdef DMEM_ARB_WATCHDOG_EN
      chk("t3_fault_sticky", fault_starve, 1);
`endif

      // Reset during RESP of a debug read; tie rule must restart with debug winning
      do_reset();
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h0;
      @(negedge clk);
      chk("t4_dbg_gnt", dbg_gnt, 1);
      dbg_req = 0;
      @(posedge clk); #2 reset = 1'b1;
      #1;
      chk("t4_rst_dbg_rvalid", dbg_rvalid, 0);
      chk("t4_rst_dbg_rdata", dbg_rdata, 0);
      chk("t4_rst_mem_en", mem_en, 0);
      chk("t4_rst_cpu_gnt", cpu_gnt, 0);
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h4;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h8;
      @(negedge clk);
      chk("t4_tie_dbg_gnt", dbg_gnt, 1);
      chk("t4_tie_cpu_gnt", cpu_gnt, 0);
      cpu_req = 0; dbg_req = 0;

      // Random read/write mix from both ports
      grants = 0; rd_seen = 0;
      for (int c = 0; c < 4000 && grants < 100; c++) begin
         @(negedge clk);
         if (cpu_gnt) grants++;
         if (dbg_gnt) grants++;
         if (cpu_rvalid || dbg_rvalid) rd_seen++;
         if (cpu_gnt || !cpu_req) begin
            if ($urandom_range(0, 1) == 1) begin
               cpu_req = 1; rand_cmd(cpu_we, cpu_addr, cpu_wdata);
            end else cpu_req = 0;
         end else if ($urandom_range(0, 31) == 0) cpu_req = 0;
         if (dbg_gnt || !dbg_req) begin
            if ($urandom_range(0, 1) == 1) begin
               dbg_req = 1; rand_cmd(dbg_we, dbg_addr, dbg_wdata);
            end else dbg_req = 0;
         end else if ($urandom_range(0, 31) == 0) dbg_req = 0;
         if ($urandom_range(0, 19) == 0) dbg_lock = ~dbg_lock;
      end
      chk("t5_random_grants", grants >= 100, 1);
      chk("t5_loads_seen", rd_seen > 0, 1);
      cpu_req = 0; dbg_req = 0; dbg_lock = 0;
      repeat (4) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
